// File: rtl/inta_cycle_sequencer_if.sv
// Interrupt-acknowledge bus between the 8259A side, the sequencer
// and the CPU-side vector consumer.
interface inta_cycle_sequencer_if;
    logic       interrupt_to_cpu;
    logic       interrupt_enable;
    logic [7:0] data_bus_in;
    logic       interrupt_acknowledge_n;
    logic       acknowledge_busy;
    logic [7:0] vector;
    logic       vector_valid;
    logic       vector_ready;

    modport master (
        input  interrupt_to_cpu,
        input  interrupt_enable,
        input  data_bus_in,
        input  vector_ready,
        output interrupt_acknowledge_n,
        output acknowledge_busy,
        output vector,
        output vector_valid
    );

    modport slave (
        output interrupt_to_cpu,
        output interrupt_enable,
        output data_bus_in,
        output vector_ready,
        input  interrupt_acknowledge_n,
        input  acknowledge_busy,
        input  vector,
        input  vector_valid
    );
endinterface

// File: rtl/inta_cycle_sequencer.sv
// CPU-side 8086-mode INTA# two-pulse sequencer for the 8259A,
// capturing the vector and presenting it over valid/ready.
module inta_cycle_sequencer #(
    parameter int PULSE_WIDTH   = 2,
    parameter int GAP_WIDTH     = 2,
    parameter int RECOVER_WIDTH = 3
) (
    input logic                    clock,
    input logic                    reset_n,
    inta_cycle_sequencer_if.master bus
);
    localparam int MAXW_PG = (PULSE_WIDTH > GAP_WIDTH) ? PULSE_WIDTH : GAP_WIDTH;
    localparam int MAXW    = (MAXW_PG > RECOVER_WIDTH) ? MAXW_PG : RECOVER_WIDTH;
    localparam int CW      = $clog2(MAXW) + 1;

    typedef enum logic [2:0] {
        IDLE,
        ACK1,
        GAP,
        ACK2,
        RECOVER
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           sync1_q, sync2_q;
    logic           inta_n_q, inta_n_d;
    logic           busy_q, busy_d;
    logic [7:0]     vector_q, vector_d;
    logic           valid_q, valid_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            inta_n_q <= 1'b1;
            busy_q   <= 1'b0;
            vector_q <= 8'h00;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sync1_q  <= bus.interrupt_to_cpu;
            sync2_q  <= sync1_q;
            inta_n_q <= inta_n_d;
            busy_q   <= busy_d;
            vector_q <= vector_d;
            valid_q  <= valid_d;
        end
    end

    // Counter is loaded with width-1 on entry; a state exits when it reads zero.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        vector_d = vector_q;
        valid_d  = valid_q;
        if (valid_q && bus.vector_ready) begin
            valid_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (sync2_q && bus.interrupt_enable && !valid_q) begin
                    state_d = ACK1;
                    cnt_d   = CW'(PULSE_WIDTH - 1);
                end
            end
            ACK1: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = CW'(GAP_WIDTH - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = ACK2;
                    cnt_d   = CW'(PULSE_WIDTH - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ACK2: begin
                if (cnt_q == '0) begin
                    state_d  = RECOVER;
                    cnt_d    = CW'(RECOVER_WIDTH - 1);
                    vector_d = bus.data_bus_in;
                    valid_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RECOVER: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        inta_n_d = !((state_d == ACK1) || (state_d == ACK2));
        busy_d   = (state_d != IDLE);
    end

    assign bus.interrupt_acknowledge_n = inta_n_q;
    assign bus.acknowledge_busy        = busy_q;
    assign bus.vector                  = vector_q;
    assign bus.vector_valid            = valid_q;
endmodule

// File: tb/tb_inta_cycle_sequencer.sv
// Self-checking bench: vector table, directed corner cases, a short-timing
// instance, and random stimulus against an elapsed-time reference model.
module tb_inta_cycle_sequencer;
    localparam int P   = 2;
    localparam int G   = 2;
    localparam int R   = 3;
    localparam int CAP = 2 * P + G;
    localparam int LEN = 2 * P + G + R;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inta_cycle_sequencer_if b1 ();
    inta_cycle_sequencer_if b2 ();

    inta_cycle_sequencer #(.PULSE_WIDTH(2), .GAP_WIDTH(2), .RECOVER_WIDTH(3)) dut (
        .clock(clk), .reset_n(rst_n), .bus(b1)
    );
    inta_cycle_sequencer #(.PULSE_WIDTH(1), .GAP_WIDTH(1), .RECOVER_WIDTH(2)) dut_short (
        .clock(clk), .reset_n(rst_n), .bus(b2)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       i;
        logic       e;
        logic [7:0] d;
        logic       r;
        logic       inta;
        logic       busy;
        logic       valid;
        logic [7:0] vec;
    } row_t;

    row_t tbl[$];

    function automatic row_t mk(input logic i, e, input logic [7:0] d, input logic r,
                                input logic inta, busy, valid, input logic [7:0] vec);
        row_t x;
        x.i = i; x.e = e; x.d = d; x.r = r;
        x.inta = inta; x.busy = busy; x.valid = valid; x.vec = vec;
        return x;
    endfunction

    // Reference model: tracks elapsed cycles since the sequence start.
    logic       m_s1, m_s2, m_run, m_valid;
    int         m_t;
    logic [7:0] m_vec;

    task automatic m_reset();
        m_s1 = 0; m_s2 = 0; m_run = 0; m_valid = 0; m_t = 0; m_vec = 8'h00;
    endtask

    task automatic m_edge(input logic i, input logic e, input logic [7:0] d, input logic r);
        logic sync;
        logic v_old;
        sync  = m_s2;
        v_old = m_valid;
        m_s2  = m_s1;
        m_s1  = i;
        if (v_old && r) m_valid = 0;
        if (!m_run) begin
            if (sync && e && !v_old) begin
                m_run = 1;
                m_t   = 0;
            end
        end else begin
            m_t++;
            if (m_t == LEN) begin
                m_run = 0;
            end else if (m_t == CAP) begin
                m_vec   = d;
                m_valid = 1;
            end
        end
    endtask

    function automatic logic m_inta();
        return !(m_run && (m_t < P || (m_t >= P + G && m_t < CAP)));
    endfunction

    task automatic drive1(input logic i, e, input logic [7:0] d, input logic r);
        b1.interrupt_to_cpu = i;
        b1.interrupt_enable = e;
        b1.data_bus_in      = d;
        b1.vector_ready     = r;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int fall_at;
        int cap_at;
        int end_at;
        logic seen_busy;

        drive1(0, 0, 8'h00, 0);
        b2.interrupt_to_cpu = 0;
        b2.interrupt_enable = 0;
        b2.data_bus_in      = 8'h00;
        b2.vector_ready     = 0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        chk("rst_inta", {7'd0, b1.interrupt_acknowledge_n}, 8'h01);
        chk("rst_busy", {7'd0, b1.acknowledge_busy}, 8'h00);
        chk("rst_valid", {7'd0, b1.vector_valid}, 8'h00);
        chk("rst_vector", b1.vector, 8'h00);
        rst_n = 1;

        for (int k = 0; k <= 1; k++) tbl.push_back(mk(1, 1, 8'h4B, 0, 1, 0, 0, 8'h00));
        tbl.push_back(mk(1, 1, 8'h4B, 0, 0, 1, 0, 8'h00));
        tbl.push_back(mk(1, 1, 8'h4B, 0, 0, 1, 0, 8'h00));
        tbl.push_back(mk(1, 1, 8'h4B, 0, 1, 1, 0, 8'h00));
        tbl.push_back(mk(1, 1, 8'h4B, 0, 1, 1, 0, 8'h00));
        tbl.push_back(mk(1, 1, 8'h4B, 0, 0, 1, 0, 8'h00));
        tbl.push_back(mk(1, 1, 8'h4B, 0, 0, 1, 0, 8'h00));
        for (int k = 8; k <= 10; k++) tbl.push_back(mk(1, 1, 8'h4B, 0, 1, 1, 1, 8'h4B));
        for (int k = 11; k <= 15; k++) tbl.push_back(mk(1, 1, 8'h4B, 0, 1, 0, 1, 8'h4B));
        tbl.push_back(mk(1, 1, 8'h4B, 1, 1, 0, 0, 8'h4B));
        tbl.push_back(mk(0, 1, 8'h5A, 0, 0, 1, 0, 8'h4B));
        tbl.push_back(mk(0, 1, 8'h5A, 0, 0, 1, 0, 8'h4B));
        tbl.push_back(mk(0, 1, 8'h5A, 0, 1, 1, 0, 8'h4B));
        tbl.push_back(mk(0, 1, 8'h5A, 0, 1, 1, 0, 8'h4B));
        tbl.push_back(mk(0, 1, 8'h5A, 0, 0, 1, 0, 8'h4B));
        tbl.push_back(mk(0, 1, 8'h5A, 0, 0, 1, 0, 8'h4B));
        for (int k = 23; k <= 25; k++) tbl.push_back(mk(0, 1, 8'h5A, 0, 1, 1, 1, 8'h5A));
        tbl.push_back(mk(0, 1, 8'h5A, 0, 1, 0, 1, 8'h5A));
        tbl.push_back(mk(0, 1, 8'h5A, 1, 1, 0, 0, 8'h5A));
        tbl.push_back(mk(0, 1, 8'h5A, 0, 1, 0, 0, 8'h5A));

        foreach (tbl[n]) begin
            drive1(tbl[n].i, tbl[n].e, tbl[n].d, tbl[n].r);
            step();
            chk($sformatf("tbl%0d_inta", n), {7'd0, b1.interrupt_acknowledge_n}, {7'd0, tbl[n].inta});
            chk($sformatf("tbl%0d_busy", n), {7'd0, b1.acknowledge_busy}, {7'd0, tbl[n].busy});
            chk($sformatf("tbl%0d_valid", n), {7'd0, b1.vector_valid}, {7'd0, tbl[n].valid});
            chk($sformatf("tbl%0d_vec", n), b1.vector, tbl[n].vec);
        end

        // INT high with interrupts disabled: nothing may start.
        drive1(1, 0, 8'h00, 0);
        for (int k = 0; k < 20; k++) begin
            step();
            chk("dis_inta", {7'd0, b1.interrupt_acknowledge_n}, 8'h01);
            chk("dis_busy", {7'd0, b1.acknowledge_busy}, 8'h00);
        end
        drive1(1, 1, 8'h00, 0);
        step();
        chk("en_inta_fall", {7'd0, b1.interrupt_acknowledge_n}, 8'h00);
        step();
        step();
        chk("gap_inta", {7'd0, b1.interrupt_acknowledge_n}, 8'h01);
        drive1(0, 1, 8'h47, 0);
        step();
        step();
        chk("ack2_after_drop", {7'd0, b1.interrupt_acknowledge_n}, 8'h00);
        step();
        step();
        chk("spur_valid", {7'd0, b1.vector_valid}, 8'h01);
        chk("spur_vector", b1.vector, 8'h47);
        repeat (3) step();
        chk("spur_idle", {7'd0, b1.acknowledge_busy}, 8'h00);
        drive1(0, 1, 8'h47, 1);
        step();
        drive1(0, 1, 8'h47, 0);
        chk("spur_clear", {7'd0, b1.vector_valid}, 8'h00);

        // Reset asserted in the middle of ACK2.
        drive1(1, 1, 8'h33, 0);
        fall_at = -1;
        for (int k = 0; k < 6 && fall_at < 0; k++) begin
            step();
            if (b1.interrupt_acknowledge_n === 1'b0) fall_at = k;
        end
        chk("rstmid_start_seen", {7'd0, fall_at >= 0}, 8'h01);
        repeat (4) step();
        chk("rstmid_in_ack2", {7'd0, b1.interrupt_acknowledge_n}, 8'h00);
        #2 rst_n = 0;
        #1;
        chk("rstmid_inta", {7'd0, b1.interrupt_acknowledge_n}, 8'h01);
        chk("rstmid_busy", {7'd0, b1.acknowledge_busy}, 8'h00);
        chk("rstmid_valid", {7'd0, b1.vector_valid}, 8'h00);
        chk("rstmid_vector", b1.vector, 8'h00);
        @(negedge clk);
        rst_n = 1;
        step();
        chk("restart_e1", {7'd0, b1.interrupt_acknowledge_n}, 8'h01);
        step();
        chk("restart_e2", {7'd0, b1.interrupt_acknowledge_n}, 8'h01);
        step();
        chk("restart_e3", {7'd0, b1.interrupt_acknowledge_n}, 8'h00);
        drive1(0, 0, 8'h00, 0);

        // Short-timing instance: P=1, G=1, R=2.
        b2.interrupt_to_cpu = 1;
        b2.interrupt_enable = 1;
        b2.data_bus_in      = 8'hA5;
        fall_at = -1; cap_at = -1; end_at = -1; seen_busy = 0;
        for (int k = 0; k < 40 && end_at < 0; k++) begin
            step();
            if (fall_at < 0 && b2.interrupt_acknowledge_n === 1'b0) fall_at = k;
            if (cap_at < 0 && b2.vector_valid === 1'b1) cap_at = k;
            if (b2.acknowledge_busy === 1'b1) seen_busy = 1;
            else if (seen_busy) end_at = k;
        end
        chk("short_done", {7'd0, end_at >= 0}, 8'h01);
        chk("short_cap_lat", 8'(cap_at - fall_at), 8'd3);
        chk("short_seq_len", 8'(end_at - fall_at), 8'd5);
        chk("short_vector", b2.vector, 8'hA5);
        b2.interrupt_to_cpu = 0;

        // Random stimulus against the reference model.
        @(negedge clk);
        rst_n = 0;
        m_reset();
        drive1(0, 0, 8'h00, 0);
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 1500; k++) begin
            logic ri, re, rr;
            logic [7:0] rd;
            ri = ($urandom_range(0, 9) < 7) ? b1.interrupt_to_cpu : ~b1.interrupt_to_cpu;
            re = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 4) == 0);
            rd = 8'($urandom);
            drive1(ri, re, rd, rr);
            @(posedge clk);
            m_edge(ri, re, rd, rr);
            @(negedge clk);
            chk("rnd_inta", {7'd0, b1.interrupt_acknowledge_n}, {7'd0, m_inta()});
            chk("rnd_busy", {7'd0, b1.acknowledge_busy}, {7'd0, m_run});
            chk("rnd_valid", {7'd0, b1.vector_valid}, {7'd0, m_valid});
            chk("rnd_vector", b1.vector, m_vec);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
